uart_word_tx_ctrl: RTL
======================

Name: uart_word_tx_ctrl

Overview:
Sits between the BIP datapath and uart_tx inside top. It accepts one NBITS_D-bit result word, such as the accumulator at halt, and splits it into DBIT-bit bytes, least-significant byte first. For each byte it issues a start pulse to uart_tx and waits for that transmitter's done pulse before sending the next byte. A host that receives the byte stream rebuilds the word in the order low byte, then high byte.

Parameters:
NBITS_D  16  width of the word to send; must be an integer multiple of DBIT
DBIT  8  UART data bits per frame
NBYTES  NBITS_D/DBIT  bytes per word (derived localparam, default 2)

Ports:
i_clk  input  1  system clock; all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  word available on i_data; sampled only in IDLE
i_data  input  NBITS_D  word to transmit
o_ready  output  1  high only while in IDLE
o_busy  output  1  high in SEND and WAIT
o_tx_start  output  1  one-cycle start strobe to uart_tx
o_tx_data  output  DBIT  byte presented to uart_tx
i_tx_done  input  1  one-cycle done pulse from uart_tx (end of stop bits)
o_word_done  output  1  one-cycle pulse after the last byte completes

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are i_clk and i_rst.
- Internal state:
  - shift register sh_q, NBITS_D bits
  - byte counter cnt_q, width clog2(NBYTES), minimum 1 bit
  - FSM state: IDLE, SEND, WAIT
  - word_done_q, a registered pulse
- Reset (i_rst=1 at an edge) takes priority over everything else:
  - state=IDLE, sh_q=0, cnt_q=0, word_done_q=0.
  - Outputs after reset: o_ready=1, o_busy=0, o_tx_start=0, o_tx_data=0, o_word_done=0.
  - Reset in any state, including mid-frame, abandons the word. No further o_tx_start is issued.
- IDLE:
  - If i_valid=1: sh_q<=i_data, cnt_q<=0, next state SEND.
  - Otherwise stay in IDLE.
- SEND:
  - o_tx_start=1 for exactly this one cycle.
  - Next state WAIT, unconditionally.
- WAIT:
  - o_tx_start=0.
  - On i_tx_done=1 with cnt_q==NBYTES-1: next state IDLE, word_done_q<=1.
  - On i_tx_done=1 with any other cnt_q: sh_q<=sh_q>>DBIT (zero fill), cnt_q<=cnt_q+1, next state SEND.
  - Without i_tx_done: stay in WAIT with no timeout.
- Output decode:
  - o_tx_data = sh_q[DBIT-1:0] at all times, so it is stable from SEND through WAIT.
  - o_ready = (state==IDLE).
  - o_busy = (state!=IDLE).
  - o_word_done = word_done_q. It is cleared on the following edge unless set again.
- Latency:
  - i_valid accepted at edge N: o_tx_start high during cycle N+1.
  - Gap between i_tx_done of byte k and o_tx_start of byte k+1: one cycle.
  - Last i_tx_done at edge M: o_word_done=1 and o_ready=1 during cycle M+1.
  - A new i_valid in cycle M+1 is accepted at once (back-to-back words).
- Ignored inputs:
  - i_valid while o_busy=1 is dropped. There is no queue, so upstream must hold i_valid until o_ready=1.
  - i_tx_done in IDLE or SEND is ignored and does not advance the count.
  - i_data changes after acceptance have no effect on the word in flight.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles, release. Required: o_ready=1, o_busy=0, o_tx_start=0, o_tx_data=0x00, o_word_done=0.
- Single word: i_valid with i_data=0xA55A, uart_tx driven from mod_m_counter with DIV=6. Required:
  - o_tx_start 1 cycle after acceptance with o_tx_data=0x5A.
  - After the first i_tx_done, o_tx_start with o_tx_data=0xA5.
  - o_word_done 1 cycle after the second i_tx_done.
  - A loopback uart_rx reassembles 0xA55A.
- Busy drop: accept 0x1234, then pulse i_valid with 0xBEEF while in WAIT. Required: only bytes 0x34 and 0x12 are sent, and exactly 2 o_tx_start pulses occur.
- Back-to-back: send 0x0001, then assert i_valid with 0xFFFF in the o_word_done cycle. Required: bytes 0x01, 0x00, 0xFF, 0xFF in order, and 2 o_word_done pulses.
- Spurious done: pulse i_tx_done in IDLE, and again in the SEND cycle of word 0x00C3. Required: the count does not advance, and both bytes 0xC3 and 0x00 are still sent.
- Reset mid-word: assert i_rst during WAIT of the first byte of 0x7E81. Required: state returns to IDLE and o_ready=1 the next cycle, with no second o_tx_start. A following word 0x0102 is sent as 0x02 then 0x01.

Source files
------------

// File: rtl/uart_word_tx_ctrl.sv
// Splits one NBITS_D-bit word into DBIT-bit bytes, least-significant byte first,
// and hands them one at a time to a UART transmitter using a start/done handshake.
module uart_word_tx_ctrl #(
  parameter int NBITS_D = 16,
  parameter int DBIT    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NBITS_D-1:0] i_data,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  input  logic               i_tx_done,
  output logic               o_word_done
);

  localparam int NBYTES = NBITS_D / DBIT;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [NBITS_D-1:0] sh_r;
  logic [NBITS_D-1:0] sh_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               word_done_r;
  logic               word_done_nxt_s;

  // Next-state, shift and byte-count decode; done pulses outside WAIT are ignored.
  always_comb begin
    state_nxt_s     = state_r;
    sh_nxt_s        = sh_r;
    cnt_nxt_s       = cnt_r;
    word_done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          sh_nxt_s    = i_data;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        state_nxt_s = WAIT;
      end
      WAIT: begin
        if (i_tx_done && (cnt_r == CNT_LAST)) begin
          state_nxt_s     = IDLE;
          word_done_nxt_s = 1'b1;
        end else if (i_tx_done) begin
          sh_nxt_s    = sh_r >> DBIT;
          cnt_nxt_s   = cnt_r + CNT_ONE;
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any word in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE;
      sh_r        <= {NBITS_D{1'b0}};
      cnt_r       <= CNT_ZERO;
      word_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sh_r        <= sh_nxt_s;
      cnt_r       <= cnt_nxt_s;
      word_done_r <= word_done_nxt_s;
    end
  end

  // Outputs decode directly from registers, so they carry no combinational input paths.
  assign o_tx_data   = sh_r[DBIT-1:0];
  assign o_ready     = (state_r == IDLE);
  assign o_busy      = (state_r != IDLE);
  assign o_tx_start  = (state_r == SEND);
  assign o_word_done = word_done_r;

endmodule
